alu_rs_scheduler: RTL and testbench

- Reservation-station scheduler for the single integer ALU in the out-of-order core.
- Buffers up to DEPTH dispatched ALU micro-ops and captures operand values from the CDB.
- Issues at most one ready entry per cycle to the ALU, chosen by round-robin.
- Sits between the dispatch/rename stage and the ALU. The ALU result returns through the CDB, which feeds back into this block.

---
 rtl/alu_rs_scheduler.sv | 204 ++++++++++++++++++++
 tb/tb_alu_rs_scheduler.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rs_scheduler.sv
// Reservation-station scheduler for the single integer ALU.
// Holds up to DEPTH dispatched micro-ops and snoops the CDB for pending
// operands. Each cycle it issues at most one ready entry to the ALU. The
// entry is chosen round-robin, starting at the slot after the last one issued.
module alu_rs_scheduler #(
  parameter int DEPTH = 8,
  parameter int ROB_W = 4,
  parameter int OP_W  = 5
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             clear_in,
  input  logic             disp_valid_in,
  input  logic [OP_W-1:0]  disp_op_in,
  input  logic [ROB_W-1:0] disp_rob_id_in,
  input  logic [31:0]      disp_vj_in,
  input  logic [ROB_W-1:0] disp_qj_in,
  input  logic             disp_qj_busy_in,
  input  logic [31:0]      disp_vk_in,
  input  logic [ROB_W-1:0] disp_qk_in,
  input  logic             disp_qk_busy_in,
  output logic             full_out,
  input  logic             cdb_valid_in,
  input  logic [ROB_W-1:0] cdb_rob_id_in,
  input  logic [31:0]      cdb_value_in,
  output logic             alu_valid_out,
  output logic [OP_W-1:0]  alu_op_out,
  output logic [31:0]      alu_a_out,
  output logic [31:0]      alu_b_out,
  output logic [ROB_W-1:0] alu_rob_id_out
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  // Per-entry station storage
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] bj_q;
  logic [DEPTH-1:0] bk_q;
  logic [OP_W-1:0]  op_q  [DEPTH];
  logic [ROB_W-1:0] rob_q [DEPTH];
  logic [31:0]      vj_q  [DEPTH];
  logic [ROB_W-1:0] qj_q  [DEPTH];
  logic [31:0]      vk_q  [DEPTH];
  logic [ROB_W-1:0] qk_q  [DEPTH];

  // Occupancy and round-robin start point
  logic [CNT_W-1:0] count_q;
  logic [IDX_W-1:0] ptr_q;

  // Combinational decisions, all derived from the pre-edge state
  logic [DEPTH-1:0] ready;
  logic [DEPTH-1:0] wake_j;
  logic [DEPTH-1:0] wake_k;
  logic             issue_hit;
  logic [IDX_W-1:0] issue_idx;
  logic [IDX_W-1:0] cand;
  logic             free_hit;
  logic [IDX_W-1:0] free_idx;
  logic             accept;
  logic             disp_bj;
  logic             disp_bk;
  logic [31:0]      disp_vj;
  logic [31:0]      disp_vk;

  assign full_out = (count_q == CNT_W'(DEPTH));
  assign accept   = disp_valid_in && !full_out && free_hit;

  // An entry may issue only once both of its operands hold real values
  always_comb begin
    ready = valid_q & ~bj_q & ~bk_q;
  end

  // Round-robin pick: scan upward from the pointer and wrap around the station
  always_comb begin
    issue_hit = 1'b0;
    issue_idx = '0;
    cand      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cand = ptr_q + IDX_W'(i);
      if (!issue_hit && ready[cand]) begin
        issue_hit = 1'b1;
        issue_idx = cand;
      end
    end
  end

  // New dispatches go into the lowest-numbered empty slot
  always_comb begin
    free_hit = 1'b0;
    free_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!free_hit && !valid_q[i]) begin
        free_hit = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  // Tag match of the CDB broadcast against every waiting operand
  always_comb begin
    wake_j = '0;
    wake_k = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wake_j[i] = cdb_valid_in && valid_q[i] && bj_q[i] && (qj_q[i] == cdb_rob_id_in);
      wake_k[i] = cdb_valid_in && valid_q[i] && bk_q[i] && (qk_q[i] == cdb_rob_id_in);
    end
  end

  // A dispatch whose producer broadcasts in the same cycle captures the value directly
  always_comb begin
    disp_bj = disp_qj_busy_in;
    disp_vj = disp_vj_in;
    disp_bk = disp_qk_busy_in;
    disp_vk = disp_vk_in;
    if (disp_qj_busy_in && cdb_valid_in && (disp_qj_in == cdb_rob_id_in)) begin
      disp_bj = 1'b0;
      disp_vj = cdb_value_in;
    end
    if (disp_qk_busy_in && cdb_valid_in && (disp_qk_in == cdb_rob_id_in)) begin
      disp_bk = 1'b0;
      disp_vk = cdb_value_in;
    end
  end

  // Station storage: wakeup, issue invalidation and dispatch write in one edge
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      valid_q <= '0;
      bj_q    <= '0;
      bk_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i]  <= '0;
        rob_q[i] <= '0;
        vj_q[i]  <= '0;
        qj_q[i]  <= '0;
        vk_q[i]  <= '0;
        qk_q[i]  <= '0;
      end
    end else if (rdy_in) begin
      if (clear_in) begin
        valid_q <= '0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (wake_j[i]) begin
            vj_q[i] <= cdb_value_in;
            bj_q[i] <= 1'b0;
          end
          if (wake_k[i]) begin
            vk_q[i] <= cdb_value_in;
            bk_q[i] <= 1'b0;
          end
        end
        if (issue_hit) begin
          valid_q[issue_idx] <= 1'b0;
        end
        // The free slot was empty before the edge, so it never collides with
        // the issued or woken entries above
        if (accept) begin
          valid_q[free_idx] <= 1'b1;
          op_q[free_idx]    <= disp_op_in;
          rob_q[free_idx]   <= disp_rob_id_in;
          vj_q[free_idx]    <= disp_vj;
          qj_q[free_idx]    <= disp_qj_in;
          bj_q[free_idx]    <= disp_bj;
          vk_q[free_idx]    <= disp_vk;
          qk_q[free_idx]    <= disp_qk_in;
          bk_q[free_idx]    <= disp_bk;
        end
      end
    end
  end

  // Occupancy count, round-robin pointer and the registered ALU issue port
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      count_q        <= '0;
      ptr_q          <= '0;
      alu_valid_out  <= 1'b0;
      alu_op_out     <= '0;
      alu_a_out      <= '0;
      alu_b_out      <= '0;
      alu_rob_id_out <= '0;
    end else if (rdy_in) begin
      if (clear_in) begin
        count_q       <= '0;
        ptr_q         <= '0;
        alu_valid_out <= 1'b0;
      end else begin
        count_q       <= count_q + CNT_W'(accept) - CNT_W'(issue_hit);
        alu_valid_out <= issue_hit;
        if (issue_hit) begin
          alu_op_out     <= op_q[issue_idx];
          alu_a_out      <= vj_q[issue_idx];
          alu_b_out      <= vk_q[issue_idx];
          alu_rob_id_out <= rob_q[issue_idx];
          ptr_q          <= issue_idx + IDX_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_rs_scheduler.sv
// Self-checking bench for alu_rs_scheduler: directed scenarios plus a random
// phase, all compared every cycle against a queue-free array model of the station.
module tb_alu_rs_scheduler;

  localparam int DEPTH = 8;
  localparam int ROB_W = 4;
  localparam int OP_W  = 5;

  logic             clk_in = 1'b0;
  logic             rst_in;
  logic             rdy_in;
  logic             clear_in;
  logic             disp_valid_in;
  logic [OP_W-1:0]  disp_op_in;
  logic [ROB_W-1:0] disp_rob_id_in;
  logic [31:0]      disp_vj_in;
  logic [ROB_W-1:0] disp_qj_in;
  logic             disp_qj_busy_in;
  logic [31:0]      disp_vk_in;
  logic [ROB_W-1:0] disp_qk_in;
  logic             disp_qk_busy_in;
  logic             full_out;
  logic             cdb_valid_in;
  logic [ROB_W-1:0] cdb_rob_id_in;
  logic [31:0]      cdb_value_in;
  logic             alu_valid_out;
  logic [OP_W-1:0]  alu_op_out;
  logic [31:0]      alu_a_out;
  logic [31:0]      alu_b_out;
  logic [ROB_W-1:0] alu_rob_id_out;

  int n_checks = 0;
  int n_pass   = 0;
  bit checking = 1'b0;

  // Free-running clock
  always #5 clk_in = ~clk_in;

  alu_rs_scheduler #(.DEPTH(DEPTH), .ROB_W(ROB_W), .OP_W(OP_W)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
    .disp_valid_in(disp_valid_in), .disp_op_in(disp_op_in),
    .disp_rob_id_in(disp_rob_id_in), .disp_vj_in(disp_vj_in),
    .disp_qj_in(disp_qj_in), .disp_qj_busy_in(disp_qj_busy_in),
    .disp_vk_in(disp_vk_in), .disp_qk_in(disp_qk_in),
    .disp_qk_busy_in(disp_qk_busy_in), .full_out(full_out),
    .cdb_valid_in(cdb_valid_in), .cdb_rob_id_in(cdb_rob_id_in),
    .cdb_value_in(cdb_value_in), .alu_valid_out(alu_valid_out),
    .alu_op_out(alu_op_out), .alu_a_out(alu_a_out), .alu_b_out(alu_b_out),
    .alu_rob_id_out(alu_rob_id_out)
  );

  // Reference model: a plain array of entries plus the ALU output latch
  typedef struct {
    bit               valid;
    logic [OP_W-1:0]  op;
    logic [ROB_W-1:0] rob;
    logic [31:0]      vj;
    logic [ROB_W-1:0] qj;
    bit               bj;
    logic [31:0]      vk;
    logic [ROB_W-1:0] qk;
    bit               bk;
  } ent_t;

  ent_t             m_ent [DEPTH];
  int               m_ptr;
  bit               m_valid;
  logic [OP_W-1:0]  m_op;
  logic [31:0]      m_a;
  logic [31:0]      m_b;
  logic [ROB_W-1:0] m_rob;

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) if (m_ent[i].valid) n++;
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_ent[i] = '{default: '0};
    end
    m_ptr = 0; m_valid = 0; m_op = '0; m_a = '0; m_b = '0; m_rob = '0;
  endtask

  // One clock edge of the station, taken from the rules: pick, wake, dispatch
  task automatic model_step();
    int sel;
    int slot;
    bit acc;
    if (!rst_in) begin
      model_reset();
    end else if (!rdy_in) begin
      // frozen
    end else if (clear_in) begin
      for (int i = 0; i < DEPTH; i++) m_ent[i].valid = 0;
      m_ptr = 0;
      m_valid = 0;
    end else begin
      sel = -1;
      for (int k = 0; k < DEPTH; k++) begin
        int j;
        j = (m_ptr + k) % DEPTH;
        if (sel < 0 && m_ent[j].valid && !m_ent[j].bj && !m_ent[j].bk) sel = j;
      end
      acc = disp_valid_in && (m_count() < DEPTH);
      slot = -1;
      for (int i = DEPTH - 1; i >= 0; i--) if (!m_ent[i].valid) slot = i;
      if (cdb_valid_in) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (m_ent[i].valid && m_ent[i].bj && m_ent[i].qj == cdb_rob_id_in) begin
            m_ent[i].vj = cdb_value_in; m_ent[i].bj = 0;
          end
          if (m_ent[i].valid && m_ent[i].bk && m_ent[i].qk == cdb_rob_id_in) begin
            m_ent[i].vk = cdb_value_in; m_ent[i].bk = 0;
          end
        end
      end
      if (sel >= 0) begin
        m_valid = 1;
        m_op  = m_ent[sel].op;
        m_a   = m_ent[sel].vj;
        m_b   = m_ent[sel].vk;
        m_rob = m_ent[sel].rob;
        m_ent[sel].valid = 0;
        m_ptr = (sel + 1) % DEPTH;
      end else begin
        m_valid = 0;
      end
      if (acc && slot >= 0) begin
        m_ent[slot].valid = 1;
        m_ent[slot].op  = disp_op_in;
        m_ent[slot].rob = disp_rob_id_in;
        m_ent[slot].qj  = disp_qj_in;
        m_ent[slot].qk  = disp_qk_in;
        m_ent[slot].vj  = disp_vj_in;
        m_ent[slot].bj  = disp_qj_busy_in;
        m_ent[slot].vk  = disp_vk_in;
        m_ent[slot].bk  = disp_qk_busy_in;
        if (disp_qj_busy_in && cdb_valid_in && disp_qj_in == cdb_rob_id_in) begin
          m_ent[slot].vj = cdb_value_in; m_ent[slot].bj = 0;
        end
        if (disp_qk_busy_in && cdb_valid_in && disp_qk_in == cdb_rob_id_in) begin
          m_ent[slot].vk = cdb_value_in; m_ent[slot].bk = 0;
        end
      end
    end
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Every-cycle comparison of the DUT against the model, away from the clock edge
  always @(posedge clk_in) begin
    #2;
    if (checking) begin
      check_output("cyc_valid", 32'(alu_valid_out), 32'(m_valid));
      check_output("cyc_full",  32'(full_out),      32'(m_count() == DEPTH));
      check_output("cyc_op",    32'(alu_op_out),    32'(m_op));
      check_output("cyc_a",     alu_a_out,          m_a);
      check_output("cyc_b",     alu_b_out,          m_b);
      check_output("cyc_rob",   32'(alu_rob_id_out), 32'(m_rob));
    end
  end

  // One clock edge: model follows the same pre-edge inputs the DUT samples
  task automatic tick();
    @(posedge clk_in);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    disp_valid_in = 0; cdb_valid_in = 0; clear_in = 0;
    disp_op_in = '0; disp_rob_id_in = '0; disp_vj_in = '0; disp_qj_in = '0;
    disp_qj_busy_in = 0; disp_vk_in = '0; disp_qk_in = '0; disp_qk_busy_in = 0;
    cdb_rob_id_in = '0; cdb_value_in = '0;
  endtask

  task automatic apply_stimulus();
    tick();
    idle_inputs();
  endtask

  task automatic set_disp(input logic [OP_W-1:0] op, input logic [ROB_W-1:0] rob,
                          input logic [31:0] vj, input logic [ROB_W-1:0] qj, input logic bj,
                          input logic [31:0] vk, input logic [ROB_W-1:0] qk, input logic bk);
    disp_valid_in = 1; disp_op_in = op; disp_rob_id_in = rob;
    disp_vj_in = vj; disp_qj_in = qj; disp_qj_busy_in = bj;
    disp_vk_in = vk; disp_qk_in = qk; disp_qk_busy_in = bk;
  endtask

  task automatic set_cdb(input logic [ROB_W-1:0] tag, input logic [31:0] val);
    cdb_valid_in = 1; cdb_rob_id_in = tag; cdb_value_in = val;
  endtask

  // Reset asserted between edges: outputs must clear before any clock arrives
  task automatic async_reset();
    rst_in = 0;
    model_reset();
    #1;
    check_output("arst_valid", 32'(alu_valid_out), 32'd0);
    check_output("arst_op",    32'(alu_op_out),    32'd0);
    check_output("arst_a",     alu_a_out,          32'd0);
    check_output("arst_b",     alu_b_out,          32'd0);
    check_output("arst_rob",   32'(alu_rob_id_out), 32'd0);
    check_output("arst_full",  32'(full_out),      32'd0);
    tick();
    rst_in = 1;
    tick();
    check_output("rel_full",  32'(full_out),      32'd0);
    check_output("rel_valid", 32'(alu_valid_out), 32'd0);
  endtask

  // Bound on total run time
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_in = 0; rdy_in = 1;
    idle_inputs();
    model_reset();
    checking = 1;
    tick(); tick();
    rst_in = 1;
    tick();
    check_output("init_full",  32'(full_out),      32'd0);
    check_output("init_valid", 32'(alu_valid_out), 32'd0);

    // Both operands ready: issue one edge after dispatch
    set_disp(5'd1, 4'd3, 32'd5, 4'd0, 0, 32'd7, 4'd0, 0);
    apply_stimulus();
    apply_stimulus();
    check_output("add_valid", 32'(alu_valid_out), 32'd1);
    check_output("add_a",     alu_a_out,          32'd5);
    check_output("add_b",     alu_b_out,          32'd7);
    check_output("add_rob",   32'(alu_rob_id_out), 32'd3);
    apply_stimulus();
    check_output("add_drop",  32'(alu_valid_out), 32'd0);

    // Operand A waits on tag 2, broadcast two edges later
    set_disp(5'd2, 4'd4, 32'd0, 4'd2, 1, 32'd1, 4'd0, 0);
    apply_stimulus();
    apply_stimulus();
    set_cdb(4'd2, 32'h1234);
    apply_stimulus();
    check_output("wake_not_yet", 32'(alu_valid_out), 32'd0);
    apply_stimulus();
    check_output("wake_valid", 32'(alu_valid_out), 32'd1);
    check_output("wake_a",     alu_a_out,          32'h1234);
    check_output("wake_rob",   32'(alu_rob_id_out), 32'd4);

    // Broadcast in the dispatch cycle is captured by the bypass
    set_disp(5'd3, 4'd5, 32'd0, 4'd2, 1, 32'd9, 4'd0, 0);
    set_cdb(4'd2, 32'hABCD);
    apply_stimulus();
    apply_stimulus();
    check_output("byp_valid", 32'(alu_valid_out), 32'd1);
    check_output("byp_a",     alu_a_out,          32'hABCD);
    check_output("byp_rob",   32'(alu_rob_id_out), 32'd5);

    // Three entries held, then reset mid-cycle
    for (int i = 0; i < 3; i++) begin
      set_disp(5'(i), 4'(i + 7), 32'd0, 4'd14, 1, 32'd0, 4'd0, 0);
      apply_stimulus();
    end
    async_reset();

    // Round robin: move pointer to 2, then four entries ready together
    set_disp(5'd4, 4'd1, 32'd1, 4'd0, 0, 32'd1, 4'd0, 0);
    apply_stimulus();
    set_disp(5'd4, 4'd2, 32'd2, 4'd0, 0, 32'd2, 4'd0, 0);
    apply_stimulus();
    check_output("rr_pre1", 32'(alu_rob_id_out), 32'd1);
    apply_stimulus();
    check_output("rr_pre2", 32'(alu_rob_id_out), 32'd2);
    for (int i = 0; i < 4; i++) begin
      set_disp(5'd6, 4'(10 + i), 32'd0, 4'd9, 1, 32'(i), 4'd0, 0);
      apply_stimulus();
    end
    set_cdb(4'd9, 32'h99);
    apply_stimulus();
    begin
      logic [3:0] order [4] = '{4'd12, 4'd13, 4'd10, 4'd11};
      for (int i = 0; i < 4; i++) begin
        apply_stimulus();
        check_output("rr_valid", 32'(alu_valid_out), 32'd1);
        check_output("rr_order", 32'(alu_rob_id_out), 32'(order[i]));
      end
    end
    apply_stimulus();

    // Fill the station, drop a ninth, wake entry 5
    for (int i = 0; i < DEPTH; i++) begin
      set_disp(5'(i), 4'(i), 32'd0, 4'(i), 1, 32'(i * 3), 4'd0, 0);
      apply_stimulus();
    end
    check_output("full_set", 32'(full_out), 32'd1);
    set_disp(5'd9, 4'd15, 32'd0, 4'd15, 0, 32'd0, 4'd0, 0);
    apply_stimulus();
    check_output("full_drop", 32'(full_out), 32'd1);
    check_output("full_nodisp", 32'(alu_valid_out), 32'd0);
    set_cdb(4'd5, 32'h55);
    apply_stimulus();
    check_output("full_wait", 32'(alu_valid_out), 32'd0);
    set_disp(5'd9, 4'd14, 32'd0, 4'd13, 1, 32'd0, 4'd0, 0);
    apply_stimulus();
    check_output("full_iss_valid", 32'(alu_valid_out), 32'd1);
    check_output("full_iss_rob",   32'(alu_rob_id_out), 32'd5);
    check_output("full_iss_a",     alu_a_out,          32'h55);
    check_output("full_clear",     32'(full_out),      32'd0);

    // Flush, then refill to confirm the count restarted at zero
    clear_in = 1;
    apply_stimulus();
    check_output("clr_valid", 32'(alu_valid_out), 32'd0);
    check_output("clr_full",  32'(full_out),      32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      set_disp(5'd1, 4'(i), 32'd0, 4'd15, 1, 32'd0, 4'd0, 0);
      apply_stimulus();
      check_output("refill_full", 32'(full_out), 32'(i == DEPTH - 1));
    end
    clear_in = 1;
    apply_stimulus();

    // Freeze with an entry ready, while CDB, dispatch and clear toggle
    set_disp(5'd7, 4'd6, 32'h11, 4'd0, 0, 32'h22, 4'd0, 0);
    apply_stimulus();
    rdy_in = 0;
    for (int i = 0; i < 3; i++) begin
      set_disp(5'd8, 4'd8, 32'd0, 4'd0, 0, 32'd0, 4'd0, 0);
      if (i != 1) set_cdb(4'(i), 32'(i + 100));
      clear_in = (i == 1);
      apply_stimulus();
      check_output("frz_valid", 32'(alu_valid_out), 32'd0);
    end
    rdy_in = 1;
    apply_stimulus();
    check_output("frz_valid_after", 32'(alu_valid_out), 32'd1);
    check_output("frz_a",   alu_a_out,          32'h11);
    check_output("frz_b",   alu_b_out,          32'h22);
    check_output("frz_rob", 32'(alu_rob_id_out), 32'd6);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rdy_in   = ($urandom % 8) != 0;
      clear_in = ($urandom % 64) == 0;
      if ($urandom % 2 == 0) begin
        set_disp(OP_W'($urandom), ROB_W'($urandom), $urandom, ROB_W'($urandom),
                 1'($urandom % 2), $urandom, ROB_W'($urandom), 1'($urandom % 2));
      end
      if ($urandom % 3 != 0) set_cdb(ROB_W'($urandom), $urandom);
      if (c == 1500) begin
        idle_inputs();
        rdy_in = 1;
        async_reset();
      end else begin
        apply_stimulus();
      end
    end
    rdy_in = 1;
    apply_stimulus();
    apply_stimulus();

    checking = 0;
    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
